// File: rtl/serial_char_assembler_if.sv
// serial_char_assembler_if
//   Bundle between the bit sampler / character consumer and the character
//   assembler.
//   master: drives enable, bit_valid, bit_data, char_ready; observes results.
//   slave : the assembler; consumes bits, presents the buffered character.
//   enable       receive enable (low aborts the character in progress)
//   bit_valid    one-cycle strobe qualifying bit_data
//   bit_data     sampled serial bit
//   char_ready   consumer accepts the buffered character
//   char_valid   buffered character available
//   char_data    buffered character, DATA_BITS wide
//   parity_error parity mismatch for the buffered character
//   overrun      sticky: a completed character was dropped
//   bit_count    bits accepted so far in the current character
interface serial_char_assembler_if #(
    parameter int DATA_BITS = 8
);
    localparam int CW = $clog2(DATA_BITS + 2);

    logic                 enable;
    logic                 bit_valid;
    logic                 bit_data;
    logic                 char_ready;
    logic                 char_valid;
    logic [DATA_BITS-1:0] char_data;
    logic                 parity_error;
    logic                 overrun;
    logic [CW-1:0]        bit_count;

    modport master (
        output enable, bit_valid, bit_data, char_ready,
        input  char_valid, char_data, parity_error, overrun, bit_count
    );

    modport slave (
        input  enable, bit_valid, bit_data, char_ready,
        output char_valid, char_data, parity_error, overrun, bit_count
    );
endinterface

// File: rtl/serial_char_assembler.sv
// serial_char_assembler
//   Serial-to-parallel character assembler. Shifts DATA_BITS data bits plus
//   an optional parity bit into a character and hands it to the consumer
//   through a one-entry valid/ready buffer with parity-error and overrun
//   reporting.
//   Parameters: DATA_BITS (5..9), PARITY_MODE (0 none, 1 even, 2 odd),
//               LSB_FIRST (1: first bit -> char_data[0]).
//   Ports: clk, reset (synchronous, active-high), bus (slave modport of
//          serial_char_assembler_if, DATA_BITS must match).
module serial_char_assembler #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int LSB_FIRST   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_char_assembler_if.slave  bus
);
    localparam int CW = $clog2(DATA_BITS + 2);
    localparam bit HAS_PARITY = (PARITY_MODE != 0);

    // DONE is the one-cycle landing state after a parity bit; it accepts a
    // new first bit exactly like DATA so back-to-back characters need no gap.
    typedef enum logic [1:0] {DATA, PARITY, DONE} state_t;

    state_t               state, stateNext;
    logic [DATA_BITS-1:0] shiftReg, shiftNext, shiftIn;
    logic [CW-1:0]        bitCount, countNext;
    logic                 charValid, parityErr, overrunReg;
    logic [DATA_BITS-1:0] charData;

    logic                 accept, lastData, complete, compPerr;
    logic                 load, drop;
    logic [DATA_BITS-1:0] compData;

    assign accept   = bus.enable && bus.bit_valid;
    assign lastData = accept && (state != PARITY) && (bitCount == CW'(DATA_BITS - 1));

    // Shift direction places the first received bit at bit 0 (LSB_FIRST)
    // or at the top bit after DATA_BITS shifts.
    assign shiftIn = (LSB_FIRST != 0) ? {bus.bit_data, shiftReg[DATA_BITS-1:1]}
                                      : {shiftReg[DATA_BITS-2:0], bus.bit_data};

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= DATA;
        else       state <= stateNext;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        stateNext = state;
        if (!bus.enable) begin
            stateNext = DATA;
        end else begin
            case (state)
                DATA, DONE: begin
                    stateNext = DATA;
                    if (lastData && HAS_PARITY) stateNext = PARITY;
                end
                PARITY:  if (bus.bit_valid) stateNext = DONE;
                default: stateNext = DATA;
            endcase
        end
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        shiftNext = shiftReg;
        countNext = bitCount;
        complete  = 1'b0;
        compData  = shiftIn;
        compPerr  = 1'b0;
        if (!bus.enable) begin
            shiftNext = '0;
            countNext = '0;
        end else if (bus.bit_valid) begin
            if (state == PARITY) begin
                complete  = 1'b1;
                compData  = shiftReg;
                compPerr  = ((^shiftReg) ^ bus.bit_data) != (PARITY_MODE == 2);
                countNext = '0;
            end else begin
                shiftNext = shiftIn;
                if (lastData) begin
                    countNext = HAS_PARITY ? CW'(DATA_BITS) : '0;
                    complete  = !HAS_PARITY;
                end else begin
                    countNext = bitCount + 1'b1;
                end
            end
        end
    end

    // Completion is judged against the pre-edge buffer: a slot frees up
    // when the current character is being accepted on this same edge.
    assign load = complete && (!charValid || bus.char_ready);
    assign drop = complete && charValid && !bus.char_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            shiftReg   <= '0;
            bitCount   <= '0;
            charValid  <= 1'b0;
            charData   <= '0;
            parityErr  <= 1'b0;
            overrunReg <= 1'b0;
        end else begin
            shiftReg <= shiftNext;
            bitCount <= countNext;
            if (load) begin
                charValid <= 1'b1;
                charData  <= compData;
                parityErr <= compPerr;
            end else if (charValid && bus.char_ready) begin
                charValid <= 1'b0;
            end
            if (!bus.enable) overrunReg <= 1'b0;
            else if (drop)   overrunReg <= 1'b1;
        end
    end

    assign bus.char_valid   = charValid;
    assign bus.char_data    = charData;
    assign bus.parity_error = parityErr;
    assign bus.overrun      = overrunReg;
    assign bus.bit_count    = bitCount;
endmodule

// File: tb/tb_serial_char_assembler.sv
// tb_serial_char_assembler
//   Three assembler instances share one bit stream:
//     A: 8 data bits, no parity, LSB first
//     B: 8 data bits, even parity, MSB first
//     C: 7 data bits, odd parity, LSB first
//   A reference model per instance collects received bits in a queue and
//   builds characters arithmetically; delivered characters go to a
//   scoreboard that a separate monitor drains on each handshake.
module tb_serial_char_assembler;
    logic clk = 1'b0;
    logic reset, enable, bitValid, bitData, charReady;

    always #5 clk = ~clk;

    serial_char_assembler_if #(.DATA_BITS(8)) ifA ();
    serial_char_assembler_if #(.DATA_BITS(8)) ifB ();
    serial_char_assembler_if #(.DATA_BITS(7)) ifC ();

    assign ifA.enable = enable;  assign ifA.bit_valid = bitValid;
    assign ifA.bit_data = bitData; assign ifA.char_ready = charReady;
    assign ifB.enable = enable;  assign ifB.bit_valid = bitValid;
    assign ifB.bit_data = bitData; assign ifB.char_ready = charReady;
    assign ifC.enable = enable;  assign ifC.bit_valid = bitValid;
    assign ifC.bit_data = bitData; assign ifC.char_ready = charReady;

    serial_char_assembler #(.DATA_BITS(8), .PARITY_MODE(0), .LSB_FIRST(1))
        dutA (.clk(clk), .reset(reset), .bus(ifA));
    serial_char_assembler #(.DATA_BITS(8), .PARITY_MODE(1), .LSB_FIRST(0))
        dutB (.clk(clk), .reset(reset), .bus(ifB));
    serial_char_assembler #(.DATA_BITS(7), .PARITY_MODE(2), .LSB_FIRST(1))
        dutC (.clk(clk), .reset(reset), .bus(ifC));

    int nb[3] = '{8, 8, 7};
    int pm[3] = '{0, 1, 2};
    int lf[3] = '{1, 0, 1};

    logic [8:0] dData[3];
    logic       dValid[3], dPerr[3], dOvr[3];
    logic [3:0] dCnt[3];

    assign dData[0] = {1'b0, ifA.char_data};
    assign dData[1] = {1'b0, ifB.char_data};
    assign dData[2] = {2'b0, ifC.char_data};
    assign dValid[0] = ifA.char_valid; assign dValid[1] = ifB.char_valid; assign dValid[2] = ifC.char_valid;
    assign dPerr[0] = ifA.parity_error; assign dPerr[1] = ifB.parity_error; assign dPerr[2] = ifC.parity_error;
    assign dOvr[0] = ifA.overrun; assign dOvr[1] = ifB.overrun; assign dOvr[2] = ifC.overrun;
    assign dCnt[0] = ifA.bit_count; assign dCnt[1] = ifB.bit_count; assign dCnt[2] = ifC.bit_count;

    int total = 0;
    int bad   = 0;

    // reference model state: expected outputs after the coming edge
    int         mBits[3][$];
    logic [9:0] sb[3][$];          // {parity_error, data}
    bit         eV[3], eO[3];
    int         eC[3];
    bit         prevV[3];

    task automatic chk(input string name, input int inst, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    // Applies the rules to the inputs about to be clocked in.
    task automatic modelStep();
        for (int i = 0; i < 3; i++) begin
            bit comp;
            int dat, perr, ones;
            comp = 0; dat = 0; perr = 0; ones = 0;
            if (reset) begin
                mBits[i].delete();
                eV[i] = 0;
                eO[i] = 0;
            end else begin
                if (!enable) begin
                    mBits[i].delete();
                    eO[i] = 0;
                end else if (bitValid) begin
                    mBits[i].push_back(int'(bitData));
                    if (mBits[i].size() == nb[i] + ((pm[i] != 0) ? 1 : 0)) begin
                        for (int k = 0; k < nb[i]; k++) begin
                            if (mBits[i][k] != 0) begin
                                dat = dat + (1 << ((lf[i] != 0) ? k : nb[i] - 1 - k));
                                ones++;
                            end
                        end
                        if (pm[i] != 0)
                            perr = (((ones + mBits[i][nb[i]]) % 2) != ((pm[i] == 2) ? 1 : 0)) ? 1 : 0;
                        comp = 1;
                        mBits[i].delete();
                    end
                end
                if (comp) begin
                    if (!eV[i] || charReady) begin
                        sb[i].push_back(10'(perr * 512 + dat));
                        eV[i] = 1;
                    end else begin
                        eO[i] = 1;
                    end
                end else if (eV[i] && charReady) begin
                    eV[i] = 0;
                end
            end
            eC[i] = mBits[i].size();
        end
    endtask

    // Monitor: samples mid-cycle, after the edge and before new stimulus.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) sb[i].delete();
            else if (prevV[i] && charReady && sb[i].size() > 0) void'(sb[i].pop_front());
            chk("char_valid", i, int'(dValid[i]), int'(eV[i]));
            chk("overrun",    i, int'(dOvr[i]),   int'(eO[i]));
            chk("bit_count",  i, int'(dCnt[i]),   eC[i]);
            if (dValid[i]) begin
                if (sb[i].size() == 0) chk("sb_empty", i, 1, 0);
                else chk("char", i, int'({dPerr[i], dData[i]}), int'(sb[i][0]));
            end
            prevV[i] = dValid[i];
        end
    end

    task automatic cyc(input logic r, input logic en, input logic bv, input logic bd, input logic rdy);
        @(negedge clk); #1;
        reset = r; enable = en; bitValid = bv; bitData = bd; charReady = rdy;
        modelStep();
    endtask

    task automatic sendChar(input logic [8:0] val, input int n, input logic rdy);
        for (int k = 0; k < n; k++) cyc(0, 1, 1, val[k], rdy);
    endtask

    task automatic flush();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; enable = 0; bitValid = 0; bitData = 0; charReady = 0;
        for (int i = 0; i < 3; i++) prevV[i] = 0;
        modelStep();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("rst_data", 0, int'(ifA.char_data), 0);
        chk("rst_perr", 1, int'(ifB.parity_error), 0);

        // basic receive: 1,0,1,0,0,1,0,1
        sendChar(9'h0A5, 8, 0);
        cyc(0, 1, 0, 0, 0);
        chk("basic_data", 0, int'(ifA.char_data), 'hA5);
        chk("basic_cnt",  0, int'(ifA.bit_count), 0);
        chk("msb_cnt",    1, int'(ifB.bit_count), 8);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0);
        chk("basic_drop", 0, int'(ifA.char_valid), 0);
        flush();

        // parity: 0x07 with parity bit 1, then 0
        sendChar(9'h107, 9, 0);
        cyc(0, 1, 0, 0, 0);
        chk("par_even_ok", 1, int'(ifB.parity_error), 0);
        chk("par_odd_ok",  2, int'(ifC.parity_error), 0);
        flush();
        sendChar(9'h007, 9, 0);
        cyc(0, 1, 0, 0, 0);
        chk("par_even_bad", 1, int'(ifB.parity_error), 1);
        flush();

        // overrun
        sendChar(9'h011, 8, 0);
        sendChar(9'h022, 8, 0);
        cyc(0, 1, 0, 0, 0);
        chk("ovr_data", 0, int'(ifA.char_data), 'h11);
        chk("ovr_flag", 0, int'(ifA.overrun), 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("ovr_clear", 0, int'(ifA.overrun), 0);
        chk("ovr_keep",  0, int'(ifA.char_valid), 1);
        flush();

        // simultaneous accept and complete
        sendChar(9'h033, 8, 1);
        sendChar(9'h044, 8, 1);
        cyc(0, 1, 0, 0, 0);
        chk("b2b_data", 0, int'(ifA.char_data), 'h44);
        flush();

        // abort mid-character
        sendChar(9'h00F, 4, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("abort_cnt", 0, int'(ifA.bit_count), 0);
        sendChar(9'h0C3, 8, 0);
        cyc(0, 1, 0, 0, 0);
        chk("abort_data", 0, int'(ifA.char_data), 'hC3);
        sendChar(9'h00F, 4, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("rst_abort_cnt", 0, int'(ifA.bit_count), 0);
        flush();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 49) != 0),
                ($urandom_range(0, 9) < 7),
                1'($urandom),
                ($urandom_range(0, 9) < 4));
        end
        cyc(0, 1, 0, 0, 0);
        @(negedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
